hourly_tally: RTL and testbench
===============================

Name: hourly_tally

Overview:
- Upstream data source for the parking-lot history display.
- Counts car-entry events over fixed-length "hour" windows and commits each hour's total into an internal 8-entry history memory.
- Serves that memory through a read port addressed by the 4-bit hour-address scroller, with 1-cycle registered read latency.
- Also drives live status for the current hour and a day-complete flag.

Parameters:
- HOURS, 8, number of hour slots in the history memory (addresses 0..HOURS-1).
- CNT_W, 4, width of each stored count; counts saturate at 2^CNT_W-1.
- TICKS_PER_HOUR, 16, clk cycles per hour window while recording (≥2).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- start  input  1  one-cycle pulse; begins a day of recording from IDLE or DONE.
- car_in  input  1  one-cycle pulse per car entering the lot (pre-debounced upstream).
- rd_addr  input  4  history address from the scroller.
- rd_data  output  CNT_W  registered memory read data.
- cur_hour  output  3  hour slot currently being recorded.
- cur_count  output  CNT_W  running count for cur_hour.
- recording  output  1  high in RECORD or COMMIT.
- day_done  output  1  high in DONE.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - All memory entries = 0.
  - rd_data=0, cur_hour=0, cur_count=0, tick counter=0.
  - recording=0, day_done=0.
  - Reset mid-operation discards all history and any partial count.
- State machine:
  - IDLE: start → RECORD, with cur_hour=0, cur_count=0, tick=0. car_in is ignored.
  - RECORD: each cycle, tick increments. When tick==TICKS_PER_HOUR-1 → COMMIT. car_in increments cur_count, saturating at 2^CNT_W-1.
  - COMMIT (exactly 1 cycle): mem[cur_hour] <= cur_count, where cur_count includes a car_in on the last RECORD cycle.
    - If cur_hour==HOURS-1 → DONE.
    - Otherwise cur_hour+1, tick=0, → RECORD.
    - cur_count is reloaded to car_in (0 or 1), so a car arriving during COMMIT is credited to the next hour and is never lost.
  - DONE: memory frozen, car_in ignored, cur_count holds 0. start → RECORD, which clears all memory to 0 in that cycle and sets cur_hour=0.
- start while in RECORD or COMMIT is ignored.
- Read port:
  - rd_data <= mem[rd_addr] each posedge (1-cycle latency) in every state.
  - rd_addr ≥ HOURS reads 0.
  - A read of the address being written in COMMIT returns the old value that cycle and the new value the next cycle (read-before-write).
- Outputs:
  - recording = (state==RECORD || state==COMMIT).
  - day_done = (state==DONE).
- Arithmetic:
  - Tick counter is $clog2(TICKS_PER_HOUR) bits and wraps only via COMMIT.
  - cur_count never wraps.
- Hour length: each hour spans TICKS_PER_HOUR RECORD cycles plus 1 COMMIT cycle.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst=0 for 2 cycles, then pulse car_in 3 times without start.
  - Required: rd_data=0 for all rd_addr 0..7, cur_count=0, recording=0, day_done=0.
- Single hour:
  - Stimulus: start, then 5 car_in pulses spread within hour 0.
  - Required: after COMMIT, mem[0]=5 (rd_addr=0 gives rd_data=5 one cycle later), and cur_hour=1.
- Full day:
  - Stimulus: car_in counts 0,1,2,...,7 in hours 0..7.
  - Required: day_done=1 after the 8th COMMIT, and scrolling rd_addr 0..7 returns 0..7.
  - A further car_in in DONE changes nothing.
- Boundaries:
  - Stimulus 1: car_in on the last RECORD cycle of hour 2. Required: counted in mem[2].
  - Stimulus 2: car_in in the COMMIT cycle. Required: cur_count=1 in hour 3.
  - Stimulus 3: 20 pulses in one hour. Required: stored value 15.
- Reset mid-day:
  - Stimulus: rst=0 during hour 4 after hours 0–3 are written.
  - Required: all reads 0, state IDLE; a new start restarts at cur_hour=0.
- Restart and out-of-range:
  - Stimulus 1: start in DONE. Required: memory cleared and recording=1.
  - Stimulus 2: rd_addr=8..15. Required: rd_data=0.

Source files
------------

// File: rtl/hourly_tally.sv
// Per-hour car-entry tally: counts car_in pulses over fixed hour windows,
// commits each hour's total into a small history memory served by a registered read port.
module hourly_tally #(
   parameter int HOURS          = 8,
   parameter int CNT_W          = 4,
   parameter int TICKS_PER_HOUR = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             car_in,
   input  logic [3:0]       rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic [2:0]       cur_hour,
   output logic [CNT_W-1:0] cur_count,
   output logic             recording,
   output logic             day_done
);

   localparam int               TW        = $clog2(TICKS_PER_HOUR);
   localparam int               HW        = $clog2(HOURS);
   localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_HOUR - 1);
   localparam logic [2:0]       HOUR_LAST = 3'(HOURS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, RECORD, COMMIT, DONE} state_t;

   state_t           state;
   logic [TW-1:0]    tick;
   logic [CNT_W-1:0] mem [HOURS];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         tick      <= '0;
         cur_hour  <= '0;
         cur_count <= '0;
         rd_data   <= '0;
         recording <= 1'b0;
         day_done  <= 1'b0;
         for (int i = 0; i < HOURS; i++) mem[i] <= '0;
      end else begin
         // Non-blocking read sees the pre-write contents (read-before-write).
         rd_data <= ({1'b0, rd_addr} < 5'(HOURS)) ? mem[rd_addr[HW-1:0]] : '0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RECORD;
                  recording <= 1'b1;
                  cur_hour  <= '0;
                  cur_count <= '0;
                  tick      <= '0;
               end
            end
            RECORD: begin
               if (car_in && cur_count != CNT_MAX) cur_count <= cur_count + 1'b1;
               if (tick == TICK_LAST) state <= COMMIT;
               else                   tick  <= tick + 1'b1;
            end
            COMMIT: begin
               mem[cur_hour[HW-1:0]] <= cur_count;
               tick                  <= '0;
               if (cur_hour == HOUR_LAST) begin
                  state     <= DONE;
                  recording <= 1'b0;
                  day_done  <= 1'b1;
                  cur_count <= '0;
               end else begin
                  state     <= RECORD;
                  cur_hour  <= cur_hour + 1'b1;
                  // A car arriving during the commit belongs to the next hour.
                  cur_count <= CNT_W'(car_in);
               end
            end
            DONE: begin
               if (start) begin
                  for (int i = 0; i < HOURS; i++) mem[i] <= '0;
                  state     <= RECORD;
                  recording <= 1'b1;
                  day_done  <= 1'b0;
                  cur_hour  <= '0;
                  cur_count <= '0;
                  tick      <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hourly_tally.sv
// Self-checking bench for hourly_tally: random car traffic against a time-position
// reference model (hour = elapsed slots, position within the 17-slot hour window).
module tb_hourly_tally;
   localparam int HOURS = 8;
   localparam int CNT_W = 4;
   localparam int TPH   = 16;
   localparam int CMAX  = 15;

   logic       clk = 0, rst = 0, start = 0, car_in = 0;
   logic [3:0] rd_addr = 0;
   logic [3:0] rd_data, cur_count;
   logic [2:0] cur_hour;
   logic       recording, day_done;

   int compared = 0, mismatched = 0;

   // Reference model: m_pos counts record slots used in the current hour; slot TPH is the commit.
   int m_hist [HOURS];
   int m_cnt = 0, m_hour = 0, m_pos = 0, m_rd = 0;
   bit m_active = 0, m_done = 0;

   always #5 clk = ~clk;

   hourly_tally #(.HOURS(HOURS), .CNT_W(CNT_W), .TICKS_PER_HOUR(TPH)) dut (
      .clk(clk), .rst(rst), .start(start), .car_in(car_in), .rd_addr(rd_addr),
      .rd_data(rd_data), .cur_hour(cur_hour), .cur_count(cur_count),
      .recording(recording), .day_done(day_done));

   task automatic step();
      @(posedge clk);
      if (!rst) begin
         foreach (m_hist[i]) m_hist[i] = 0;
         m_cnt = 0; m_hour = 0; m_pos = 0; m_rd = 0; m_active = 0; m_done = 0;
      end else begin
         m_rd = (rd_addr < HOURS) ? m_hist[rd_addr] : 0;
         if (!m_active) begin
            if (start) begin
               if (m_done) foreach (m_hist[i]) m_hist[i] = 0;
               m_active = 1; m_done = 0; m_pos = 0; m_cnt = 0; m_hour = 0;
            end
         end else if (m_pos < TPH) begin
            if (car_in && m_cnt < CMAX) m_cnt++;
            m_pos++;
         end else begin
            m_hist[m_hour] = m_cnt;
            m_pos = 0;
            if (m_hour == HOURS - 1) begin
               m_active = 0; m_done = 1; m_cnt = 0;
            end else begin
               m_hour++;
               m_cnt = car_in;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 0; start = 0; car_in = 0;
      step();
      rst = 1;
   endtask

   task automatic do_start();
      start = 1; step(); start = 0;
   endtask

   // Random traffic until the model reaches the given hour/slot (bounded).
   task automatic run_to(input int h, input int p, input int pct);
      int n = 0;
      while (!(m_active && m_hour == h && m_pos == p) && n < 400) begin
         car_in = ($urandom_range(99) < pct);
         step();
         n++;
      end
      car_in = 0;
      compared++;
      if (n >= 400) begin
         mismatched++;
         $display("FAIL run_to timeout: hour %0d slot %0d not reached", h, p);
      end
   endtask

   function automatic logic [15:0] mask_of(input int bits);
      logic [15:0] m = '0;
      while ($countones(m) < bits) m[$urandom_range(15)] = 1'b1;
      return m;
   endfunction

   task automatic test_reset();
      rst = 0; step(); step(); rst = 1;
      compared += 4;
      if (recording !== 1'b0) begin mismatched++; $display("FAIL reset_recording: got %b want 0", recording); end
      if (day_done !== 1'b0) begin mismatched++; $display("FAIL reset_day_done: got %b want 0", day_done); end
      if (cur_count !== 4'd0) begin mismatched++; $display("FAIL reset_cur_count: got %0d want 0", cur_count); end
      if (cur_hour !== 3'd0) begin mismatched++; $display("FAIL reset_cur_hour: got %0d want 0", cur_hour); end
      for (int i = 0; i < 3; i++) begin
         car_in = 1; step(); car_in = 0; step();
         compared += 2;
         if (cur_count !== 4'd0) begin mismatched++; $display("FAIL idle_car_count: got %0d want 0", cur_count); end
         if (recording !== 1'b0) begin mismatched++; $display("FAIL idle_recording: got %b want 0", recording); end
      end
      for (int a = 0; a < HOURS; a++) begin
         rd_addr = 4'(a); step();
         compared++;
         if (rd_data !== 4'd0) begin mismatched++; $display("FAIL reset_read[%0d]: got %0d want 0", a, rd_data); end
      end
   endtask

   task automatic test_single_hour();
      logic [15:0] m = mask_of(5);
      do_reset(); do_start();
      for (int p = 0; p < TPH; p++) begin car_in = m[p]; step(); end
      car_in = 0; rd_addr = 0;
      step();  // commit slot: read returns the old contents
      compared += 3;
      if (rd_data !== 4'd0) begin mismatched++; $display("FAIL rbw_old: got %0d want 0", rd_data); end
      if (cur_hour !== 3'd1) begin mismatched++; $display("FAIL single_hour_next: got %0d want 1", cur_hour); end
      if (cur_count !== 4'd0) begin mismatched++; $display("FAIL single_hour_reload: got %0d want 0", cur_count); end
      step();
      compared++;
      if (rd_data !== 4'd5) begin mismatched++; $display("FAIL single_hour_mem0: got %0d want 5", rd_data); end
   endtask

   task automatic test_full_day();
      do_reset(); do_start();
      for (int h = 0; h < HOURS; h++) begin
         logic [15:0] m = mask_of(h);
         for (int p = 0; p < TPH; p++) begin car_in = m[p]; step(); end
         car_in = 0; step();
      end
      compared += 2;
      if (day_done !== 1'b1) begin mismatched++; $display("FAIL day_done: got %b want 1", day_done); end
      if (recording !== 1'b0) begin mismatched++; $display("FAIL done_recording: got %b want 0", recording); end
      car_in = 1; step(); car_in = 0; step();
      compared++;
      if (cur_count !== 4'd0) begin mismatched++; $display("FAIL done_car_ignored: got %0d want 0", cur_count); end
      for (int a = 0; a < HOURS; a++) begin
         rd_addr = 4'(a); step();
         compared++;
         if (rd_data !== 4'(a)) begin mismatched++; $display("FAIL day_read[%0d]: got %0d want %0d", a, rd_data, a); end
      end
      for (int a = HOURS; a < 16; a++) begin
         rd_addr = 4'(a); step();
         compared++;
         if (rd_data !== 4'd0) begin mismatched++; $display("FAIL oor_read[%0d]: got %0d want 0", a, rd_data); end
      end
   endtask

   // Expects to begin in DONE with mem[5] == 5 (left by test_full_day).
   task automatic test_restart();
      rd_addr = 5; start = 1; step(); start = 0;
      compared += 3;
      if (recording !== 1'b1) begin mismatched++; $display("FAIL restart_recording: got %b want 1", recording); end
      if (cur_hour !== 3'd0) begin mismatched++; $display("FAIL restart_hour: got %0d want 0", cur_hour); end
      if (rd_data !== 4'd5) begin mismatched++; $display("FAIL restart_old_read: got %0d want 5", rd_data); end
      for (int a = 0; a < HOURS; a++) begin
         rd_addr = 4'(a); step();
         compared++;
         if (rd_data !== 4'd0) begin mismatched++; $display("FAIL restart_cleared[%0d]: got %0d want 0", a, rd_data); end
      end
   endtask

   task automatic test_boundaries();
      int exp2;
      do_reset(); do_start();
      run_to(2, TPH - 1, 30);
      exp2 = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      for (int i = 0; i < 20; i++) begin
         car_in = 1; step();
         if (i == 1) begin
            compared += 2;
            if (cur_hour !== 3'd3) begin mismatched++; $display("FAIL commit_car_hour: got %0d want 3", cur_hour); end
            if (cur_count !== 4'd1) begin mismatched++; $display("FAIL commit_car_count: got %0d want 1", cur_count); end
         end
         if (i == 17) begin
            compared++;
            if (cur_count !== 4'd15) begin mismatched++; $display("FAIL saturate_live: got %0d want 15", cur_count); end
         end
      end
      car_in = 0;
      rd_addr = 2; step();
      compared++;
      if (rd_data !== 4'(exp2)) begin mismatched++; $display("FAIL last_slot_mem2: got %0d want %0d", rd_data, exp2); end
      rd_addr = 3; step();
      compared++;
      if (rd_data !== 4'd15) begin mismatched++; $display("FAIL saturate_mem3: got %0d want 15", rd_data); end
   endtask

   task automatic test_reset_mid_day();
      do_reset(); do_start();
      run_to(4, $urandom_range(1, TPH - 1), 50);
      rst = 0; step(); rst = 1;
      compared += 3;
      if (recording !== 1'b0) begin mismatched++; $display("FAIL mid_reset_recording: got %b want 0", recording); end
      if (cur_hour !== 3'd0) begin mismatched++; $display("FAIL mid_reset_hour: got %0d want 0", cur_hour); end
      if (cur_count !== 4'd0) begin mismatched++; $display("FAIL mid_reset_count: got %0d want 0", cur_count); end
      for (int a = 0; a < HOURS; a++) begin
         rd_addr = 4'(a); step();
         compared++;
         if (rd_data !== 4'd0) begin mismatched++; $display("FAIL mid_reset_read[%0d]: got %0d want 0", a, rd_data); end
      end
      do_start();
      compared += 2;
      if (recording !== 1'b1) begin mismatched++; $display("FAIL mid_restart_recording: got %b want 1", recording); end
      if (cur_hour !== 3'd0) begin mismatched++; $display("FAIL mid_restart_hour: got %0d want 0", cur_hour); end
   endtask

   // Random traffic, random reads and stray start pulses, compared every cycle with the model.
   task automatic test_random_day();
      do_reset(); do_start();
      for (int n = 0; n < HOURS * (TPH + 1) + 20; n++) begin
         car_in  = ($urandom_range(99) < 45);
         start   = ($urandom_range(99) < 3) && !m_done;
         rd_addr = 4'($urandom_range(15));
         step();
         compared += 5;
         if (rd_data !== 4'(m_rd)) begin mismatched++; $display("FAIL rand_rd_data@%0d: got %0d want %0d", n, rd_data, m_rd); end
         if (cur_count !== 4'(m_cnt)) begin mismatched++; $display("FAIL rand_cur_count@%0d: got %0d want %0d", n, cur_count, m_cnt); end
         if (cur_hour !== 3'(m_hour)) begin mismatched++; $display("FAIL rand_cur_hour@%0d: got %0d want %0d", n, cur_hour, m_hour); end
         if (recording !== m_active) begin mismatched++; $display("FAIL rand_recording@%0d: got %b want %b", n, recording, m_active); end
         if (day_done !== m_done) begin mismatched++; $display("FAIL rand_day_done@%0d: got %b want %b", n, day_done, m_done); end
      end
      start = 0; car_in = 0;
   endtask

   initial begin
      test_reset();
      test_single_hour();
      test_full_day();
      test_restart();
      test_boundaries();
      test_reset_mid_day();
      test_random_day();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
